// File: rtl/shifter_pkg.sv
// Shared constants for the shift-loader / serializer pair.
// Holds the common word width, the default inter-frame gap and the loader FSM encoding.
package shifter_pkg;

    localparam int WIDTH_DEF = 20;
    localparam int GAP_DEF   = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_LATCH = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

endpackage

// File: rtl/shift_loader_if.sv
// Upstream word handshake plus the serializer-side strobes of the shift loader.
// The master side offers words and flush; the slave side is the loader.
interface shift_loader_if #(parameter int WIDTH = shifter_pkg::WIDTH_DEF);

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             flush;
    logic             load;
    logic [WIDTH-1:0] val;
    logic             bit_valid;
    logic             latch;
    logic             busy;
    logic [7:0]       word_count;

    modport master (
        output in_valid, in_data, flush,
        input  in_ready, load, val, bit_valid, latch, busy, word_count
    );

    modport slave (
        input  in_valid, in_data, flush,
        output in_ready, load, val, bit_valid, latch, busy, word_count
    );

endinterface

// File: rtl/word_fifo.sv
// Two-entry word buffer in front of the loader FSM.
// Push and pop in the same cycle are both honoured; flush empties it.
module word_fifo #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_empty,
    output logic         o_full
);

    logic [W-1:0] r_mem [2];
    logic         r_rd;
    logic         r_wr;
    logic [1:0]   r_cnt;
    logic         w_push;
    logic         w_pop;

    assign o_empty = (r_cnt == 2'd0);
    assign o_full  = (r_cnt == 2'd2);
    assign o_head  = r_mem[r_rd];
    assign w_push  = i_push && !o_full && !i_flush;
    assign w_pop   = i_pop && !o_empty && !i_flush;

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd  <= 1'b0;
            r_wr  <= 1'b0;
            r_cnt <= 2'd0;
        end else if (i_flush) begin
            r_rd  <= 1'b0;
            r_wr  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (w_push)
                r_wr <= ~r_wr;
            if (w_pop)
                r_rd <= ~r_rd;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: rtl/shift_loader.sv
// Feeds buffered words to a parallel-load serializer: LOAD strobe, WIDTH bit cycles,
// a LATCH pulse, then an optional idle gap before the next frame.
module shift_loader
    import shifter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int GAP   = GAP_DEF
) (
    input logic           clk,
    input logic           reset,
    shift_loader_if.slave bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [GAP_W-1:0]   r_gap;
    logic [7:0]         r_word_count;
    logic               r_load;
    logic [WIDTH-1:0]   r_val;
    logic               r_bit_valid;
    logic               r_latch;

    logic [WIDTH-1:0]   w_head;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;

    assign w_push = bus.in_valid && !w_full && !bus.flush;
    assign w_pop  = (r_state == ST_LOAD) && !bus.flush;

    word_fifo #(.W(WIDTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_flush (bus.flush),
        .i_push  (w_push),
        .i_data  (bus.in_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign bus.in_ready   = !w_full;
    assign bus.busy       = (r_state != ST_IDLE) || !w_empty;
    assign bus.load       = r_load;
    assign bus.val        = r_val;
    assign bus.bit_valid  = r_bit_valid;
    assign bus.latch      = r_latch;
    assign bus.word_count = r_word_count;

    // Strobes are registered alongside the state they belong to, so they stay Moore.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_gap        <= '0;
            r_word_count <= 8'd0;
            r_load       <= 1'b0;
            r_val        <= '0;
            r_bit_valid  <= 1'b0;
            r_latch      <= 1'b0;
        end else begin
            r_load      <= 1'b0;
            r_val       <= '0;
            r_bit_valid <= 1'b0;
            r_latch     <= 1'b0;
            if (bus.flush) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_gap   <= '0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (!w_empty) begin
                            r_state <= ST_LOAD;
                            r_load  <= 1'b1;
                            r_val   <= w_head;
                        end
                    end
                    ST_LOAD: begin
                        r_state     <= ST_SHIFT;
                        r_cnt       <= '0;
                        r_bit_valid <= 1'b1;
                    end
                    ST_SHIFT: begin
                        if (r_cnt == CNT_LAST) begin
                            r_state <= ST_LATCH;
                            r_latch <= 1'b1;
                        end else begin
                            r_cnt       <= r_cnt + CNT_W'(1);
                            r_bit_valid <= 1'b1;
                        end
                    end
                    ST_LATCH: begin
                        r_word_count <= r_word_count + 8'd1;
                        if (GAP > 0) begin
                            r_state <= ST_GAP;
                            r_gap   <= '0;
                        end else if (!w_empty) begin
                            r_state <= ST_LOAD;
                            r_load  <= 1'b1;
                            r_val   <= w_head;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_GAP: begin
                        if (r_gap == GAP_LAST) begin
                            if (!w_empty) begin
                                r_state <= ST_LOAD;
                                r_load  <= 1'b1;
                                r_val   <= w_head;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_gap <= r_gap + GAP_W'(1);
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shift_loader.sv
// Directed bench for shift_loader: a GAP=2 instance for frame tests and a GAP=0
// instance for the wrap / 22-cycle period run, with a chained serializer model.
module tb_shift_loader;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    shift_loader_if #(.WIDTH(20)) bus ();
    shift_loader_if #(.WIDTH(20)) bus0 ();

    shift_loader #(.WIDTH(20), .GAP(2)) dut (.clk(clk), .reset(reset), .bus(bus));
    shift_loader #(.WIDTH(20), .GAP(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Chained serializer: parallel load on load, shift right while bit_valid.
    logic [19:0] sr;
    always @(posedge clk or posedge reset) begin
        if (reset)              sr <= '0;
        else if (bus.load)      sr <= bus.val;
        else if (bus.bit_valid) sr <= sr >> 1;
    end

    int exp_seq [20] = '{0,0,1,1,1,1,0,0,1,1,1,1,1,0,1,0,0,1,0,1};

    int          run = 0, run0 = 0, latch_cnt = 0, latch_cnt0 = 0;
    int          lcyc [$];
    int          lcyc0 [$];
    logic [19:0] lval [$];
    logic [19:0] lval0 [$];

    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if ($countones({bus.load, bus.bit_valid, bus.latch}) > 1 || (!bus.load && bus.val != '0)) begin
                errors++;
                $display("FAIL strobes dut: load=%b bit_valid=%b latch=%b val=%h, required one-hot-or-zero and val=0 without load",
                         bus.load, bus.bit_valid, bus.latch, bus.val);
            end
            if (bus.latch) begin
                checks++;
                if (run != 20) begin
                    errors++;
                    $display("FAIL bit_run dut: run=%0d required 20", run);
                end
                latch_cnt++;
            end
            run = bus.bit_valid ? run + 1 : 0;
            if (bus.load) begin
                lcyc.push_back(cyc);
                lval.push_back(bus.val);
            end
        end else begin
            run = 0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if ($countones({bus0.load, bus0.bit_valid, bus0.latch}) > 1 || (!bus0.load && bus0.val != '0)) begin
                errors++;
                $display("FAIL strobes dut0: load=%b bit_valid=%b latch=%b val=%h, required one-hot-or-zero and val=0 without load",
                         bus0.load, bus0.bit_valid, bus0.latch, bus0.val);
            end
            if (bus0.latch) begin
                checks++;
                if (run0 != 20) begin
                    errors++;
                    $display("FAIL bit_run dut0: run=%0d required 20", run0);
                end
                latch_cnt0++;
            end
            run0 = bus0.bit_valid ? run0 + 1 : 0;
            if (bus0.load) begin
                lcyc0.push_back(cyc);
                lval0.push_back(bus0.val);
            end
        end else begin
            run0 = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a word and hold it until accepted; waited = cycles spent with in_ready=0.
    task automatic push_word(input bit sel, input logic [19:0] d, output int waited);
        logic rdy;
        waited = 0;
        if (sel) begin bus0.in_valid = 1'b1; bus0.in_data = d; end
        else     begin bus.in_valid  = 1'b1; bus.in_data  = d; end
        forever begin
            rdy = sel ? bus0.in_ready : bus.in_ready;
            step();
            if (rdy) break;
            waited++;
            if (waited > 200) begin
                checks++; errors++;
                $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles, required acceptance", waited);
                break;
            end
        end
        if (sel) bus0.in_valid = 1'b0;
        else     bus.in_valid  = 1'b0;
    endtask

    task automatic wait_idle(input bit sel);
        for (int i = 0; i < 300; i++) begin
            if (!(sel ? bus0.busy : bus.busy)) return;
            step();
        end
        checks++; errors++;
        $display("FAIL idle_timeout: busy still 1 after 300 cycles, required 0");
    endtask

    task automatic test_reset();
        step(); step();
        checks++;
        if ({bus.load, bus.val, bus.bit_valid, bus.latch, bus.busy, bus.word_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: load=%b val=%h bv=%b latch=%b busy=%b wc=%0d, required all 0",
                     bus.load, bus.val, bus.bit_valid, bus.latch, bus.busy, bus.word_count);
        end
        checks++;
        if ({bus0.load, bus0.bit_valid, bus0.latch, bus0.busy, bus0.word_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs0: busy=%b wc=%0d, required 0", bus0.busy, bus0.word_count);
        end
        reset = 1'b0;
        step();
        checks++;
        if (bus.in_ready !== 1'b1 || bus0.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: in_ready=%b/%b required 1/1", bus.in_ready, bus0.in_ready);
        end
    endtask

    task automatic test_single();
        int w;
        push_word(0, 20'hA5F3C, w);
        checks++;
        if (bus.busy !== 1'b1 || bus.load !== 1'b0) begin
            errors++;
            $display("FAIL single_buffered: busy=%b load=%b required 1/0", bus.busy, bus.load);
        end
        step();
        checks++;
        if (bus.load !== 1'b1 || bus.val !== 20'hA5F3C) begin
            errors++;
            $display("FAIL single_load: load=%b val=%h required 1/a5f3c", bus.load, bus.val);
        end
        for (int k = 0; k < 20; k++) begin
            step();
            checks++;
            if (bus.bit_valid !== 1'b1 || int'(sr[0]) != exp_seq[k]) begin
                errors++;
                $display("FAIL single_bit%0d: bit_valid=%b out=%b required 1/%0d", k, bus.bit_valid, sr[0], exp_seq[k]);
            end
        end
        step();
        checks++;
        if (bus.latch !== 1'b1 || bus.bit_valid !== 1'b0 || bus.word_count !== 8'd0) begin
            errors++;
            $display("FAIL single_latch: latch=%b bv=%b wc=%0d required 1/0/0", bus.latch, bus.bit_valid, bus.word_count);
        end
        step();
        checks++;
        if (bus.latch !== 1'b0 || bus.word_count !== 8'd1) begin
            errors++;
            $display("FAIL single_count: latch=%b wc=%0d required 0/1", bus.latch, bus.word_count);
        end
        wait_idle(0);
    endtask

    task automatic test_back_to_back();
        int w, base;
        logic [7:0] wc;
        base = lcyc.size();
        wc = bus.word_count;
        push_word(0, 20'h12345, w);
        push_word(0, 20'hFEDCB, w);
        push_word(0, 20'h0F0F1, w);
        checks++;
        if (w < 1) begin
            errors++;
            $display("FAIL b2b_third_wait: waited=%0d required >=1", w);
        end
        wait_idle(0);
        checks++;
        if (lcyc.size() != base + 3) begin
            errors++;
            $display("FAIL b2b_loads: loads=%0d required 3", lcyc.size() - base);
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (lcyc[base+i+1] - lcyc[base+i] != 24) begin
                    errors++;
                    $display("FAIL b2b_spacing%0d: %0d cycles required 24", i, lcyc[base+i+1] - lcyc[base+i]);
                end
            end
            checks++;
            if (lval[base] !== 20'h12345 || lval[base+1] !== 20'hFEDCB || lval[base+2] !== 20'h0F0F1) begin
                errors++;
                $display("FAIL b2b_vals: %h %h %h required 12345 fedcb 0f0f1", lval[base], lval[base+1], lval[base+2]);
            end
        end
        checks++;
        if (bus.word_count !== wc + 8'd3) begin
            errors++;
            $display("FAIL b2b_count: wc=%0d required %0d", bus.word_count, wc + 8'd3);
        end
    endtask

    task automatic test_flush();
        int w, lc;
        logic [7:0] wc;
        wc = bus.word_count;
        push_word(0, 20'h11111, w);
        push_word(0, 20'h22222, w);
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (bus.bit_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_setup: bit_valid=%b required 1", bus.bit_valid);
        end
        // Flush at bit 7 with a push offered in the same cycle.
        lc = latch_cnt;
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 20'h33333;
        step();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.bit_valid !== 1'b0 || bus.load !== 1'b0 || bus.word_count !== wc) begin
            errors++;
            $display("FAIL flush_state: busy=%b bv=%b load=%b wc=%0d required 0/0/0/%0d",
                     bus.busy, bus.bit_valid, bus.load, bus.word_count, wc);
        end
        for (int i = 0; i < 30; i++) step();
        checks++;
        if (latch_cnt != lc || bus.busy !== 1'b0 || bus.word_count !== wc) begin
            errors++;
            $display("FAIL flush_quiet: latches=%0d busy=%b wc=%0d required 0/0/%0d",
                     latch_cnt - lc, bus.busy, bus.word_count, wc);
        end
    endtask

    task automatic test_reset_mid();
        int w, lc, base;
        push_word(0, 20'h5A5A5, w);
        for (int i = 0; i < 14; i++) step();
        checks++;
        if (bus.bit_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_setup: bit_valid=%b required 1", bus.bit_valid);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.load, bus.val, bus.bit_valid, bus.latch, bus.busy, bus.word_count} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: load=%b val=%h bv=%b latch=%b busy=%b wc=%0d required all 0",
                     bus.load, bus.val, bus.bit_valid, bus.latch, bus.busy, bus.word_count);
        end
        step();
        reset = 1'b0;
        step();
        lc = latch_cnt;
        base = lval.size();
        push_word(0, 20'hA5F3C, w);
        wait_idle(0);
        checks++;
        if (bus.word_count !== 8'd1 || latch_cnt != lc + 1 || lval.size() != base + 1) begin
            errors++;
            $display("FAIL rst_recover: wc=%0d latches=%0d loads=%0d required 1/1/1",
                     bus.word_count, latch_cnt - lc, lval.size() - base);
        end else begin
            checks++;
            if (lval[base] !== 20'hA5F3C) begin
                errors++;
                $display("FAIL rst_recover_val: val=%h required a5f3c", lval[base]);
            end
        end
    endtask

    task automatic test_wrap();
        int w, bad_gap, bad_val;
        logic [19:0] d;
        lcyc0.delete();
        lval0.delete();
        latch_cnt0 = 0;
        for (int i = 0; i < 256; i++) begin
            d = 20'(i * 37 + 5);
            push_word(1, d, w);
        end
        wait_idle(1);
        checks++;
        if (bus0.word_count !== 8'd0 || latch_cnt0 != 256) begin
            errors++;
            $display("FAIL wrap_count: wc=%0d latches=%0d required 0/256", bus0.word_count, latch_cnt0);
        end
        checks++;
        if (lcyc0.size() != 256) begin
            errors++;
            $display("FAIL wrap_loads: loads=%0d required 256", lcyc0.size());
        end else begin
            bad_gap = 0;
            bad_val = 0;
            for (int i = 0; i < 256; i++) begin
                d = 20'(i * 37 + 5);
                if (lval0[i] !== d) bad_val++;
                if (i > 0 && lcyc0[i] - lcyc0[i-1] != 22) bad_gap++;
            end
            checks++;
            if (bad_gap != 0) begin
                errors++;
                $display("FAIL wrap_period: %0d intervals differ from 22 cycles, required 0", bad_gap);
            end
            checks++;
            if (bad_val != 0) begin
                errors++;
                $display("FAIL wrap_vals: %0d words wrong or lost, required 0", bad_val);
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        bus.in_valid = 1'b0;  bus.in_data = '0;  bus.flush = 1'b0;
        bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.flush = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_loader.md
SHIFT_LOADER -- requirements
Module: shift_loader

Interface
REQ-001 Parameter WIDTH, default 20: word width in bits; equals the downstream serializer width.
REQ-002 Parameter GAP, default 2: idle cycles inserted after each latch pulse; 0 means no gap.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 in_valid  input  1  upstream word offered.
REQ-006 in_data  input  WIDTH  upstream word; bit 0 is shifted out first.
REQ-007 in_ready  output  1  word accepted on a cycle with in_valid=1 and in_ready=1.
REQ-008 flush  input  1  synchronous abort; discards buffered words and any frame in progress.
REQ-009 load  output  1  one-cycle parallel-load strobe to the serializer.
REQ-010 val  output  WIDTH  word presented with load; all-zero when load=0.
REQ-011 bit_valid  output  1  high exactly on the WIDTH cycles the serializer's serial output carries word bits.
REQ-012 latch  output  1  one-cycle pulse after the last bit of a completed frame.
REQ-013 busy  output  1  high when the FSM is not in IDLE or the buffer is non-empty.
REQ-014 word_count  output  8  number of completed frames; wraps from 255 to 0.

Function
REQ-015 Input buffer: 2-entry FIFO; in_ready = !full; a push and a pop in the same cycle are both honoured.
REQ-016 FSM states: IDLE, LOAD, SHIFT, LATCH, GAP; all outputs except in_ready and busy are decoded from registered state only (Moore).
REQ-017 IDLE -> LOAD when the buffer is non-empty at the clock edge; a word pushed at edge N reaches LOAD at the earliest at edge N+1.
REQ-018 LOAD lasts 1 cycle: load=1, val=buffer head; the head is popped at the end of the cycle; then -> SHIFT.
REQ-019 SHIFT lasts exactly WIDTH cycles with bit_valid=1; a bit counter runs 0..WIDTH-1; the cycle with counter=k aligns with serial bit k.
REQ-020 SHIFT -> LATCH after counter=WIDTH-1; LATCH lasts 1 cycle with latch=1, and word_count increments at the end of that cycle.
REQ-021 LATCH -> GAP for GAP cycles, or directly to the next-state decision when GAP=0.
REQ-022 Next-state decision after LATCH/GAP: LOAD if the buffer is non-empty, else IDLE; back-to-back frame period = WIDTH+2+GAP cycles.
REQ-023 flush=1 at an edge: FSM -> IDLE and buffer emptied; no latch, no count increment; a simultaneous push is dropped.
REQ-024 flush has priority over every other transition, including a pending latch.
REQ-025 load, bit_valid and latch are mutually exclusive in every cycle.

Reset
REQ-026 On reset assertion: state=IDLE, buffer empty, counter=0, word_count=0.
REQ-027 While reset is asserted: load=0, val=0, bit_valid=0, latch=0, busy=0.
REQ-028 in_ready=1 from the first cycle after reset is released.
REQ-029 Reset asserted mid-frame aborts the frame immediately; no latch pulse is produced.

Structure
REQ-030 A shared package (shifter_pkg) holds the WIDTH default (20), the GAP default, and the FSM state encodings; the downstream serializer uses the same WIDTH constant.
REQ-031 The 2-entry buffer is a separate sub-module, word_fifo (parameterised by width, depth 2); the FSM and counters stay in shift_loader.

Verification
REQ-032 Single word: push 20'hA5F3C one cycle after reset -> load=1 with val=20'hA5F3C; then 20 bit_valid cycles; on a chained serializer, out = 0,0,1,1,1,1,0,0,1,1,1,1,1,0,1,0,0,1,0,1; then latch=1 and word_count=1.
REQ-033 Back-to-back: three words pushed on consecutive cycles -> the third waits (in_ready=0 when full); load pulses spaced 24 cycles apart with GAP=2; word_count=3; no words lost.
REQ-034 Flush mid-SHIFT: assert flush at bit 7 with one word buffered -> next cycle IDLE, busy=0, no latch pulse, word_count unchanged.
REQ-035 Reset mid-SHIFT at bit 12 -> all outputs 0 immediately; after release, a new push produces a normal full frame.
REQ-036 Wrap: 256 frames -> word_count reads 0 after the 256th latch pulse; GAP=0 build gives a frame period of 22 cycles.
REQ-037 Assertions in all tests: load, bit_valid and latch are one-hot-or-zero; bit_valid runs in blocks of exactly WIDTH cycles; when load=0, val=0.
